// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for the iterative multiplier.
// The execute stage drives the master side; the multiplier implements the slave side.
interface seq_multiplier_if #(
  parameter int WIDTH = 16
);
  logic [3:0]         control;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               validity;
  logic [2*WIDTH-1:0] result;

  modport master (
    output control, multiplicand, multiplier,
    input  busy, validity, result
  );

  modport slave (
    input  control, multiplicand, multiplier,
    output busy, validity, result
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add 16x16 multiplier for MULT/MULTU; signed ops run on magnitudes.
// Optional macro MULT_EARLY_TERM_EN ends iteration once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for an operation; result/validity held
// RUN   | one shift-add iteration per cycle
// FIX   | sign correction and result write
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_multiplier_if.slave      bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_MULT  = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      counter_q;
  logic               neg_q;
  logic               busy_q;
  logic               validity_q;

  logic               op_valid_d;
  logic               op_signed_d;
  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic               neg_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_d;
  logic               last_iter_d;
  logic [2*WIDTH-1:0] product_d;

  always_comb begin
    op_signed_d = (bus.control == OP_MULT);
    op_valid_d  = op_signed_d || (bus.control == OP_MULTU);
    // Magnitude of the most-negative value wraps to itself, which is correct as unsigned.
    a_mag_d = (op_signed_d && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;
    b_mag_d = (op_signed_d && bus.multiplier[WIDTH-1])   ? -bus.multiplier   : bus.multiplier;
    neg_d   = op_signed_d && (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_d = mplier_q >> 1;
`ifdef MULT_EARLY_TERM_EN
    last_iter_d = (mplier_d == '0) || (counter_q == CW'(WIDTH - 1));
`else
    last_iter_d = (counter_q == CW'(WIDTH - 1));
`endif
    product_d = neg_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mcand_q    <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      mplier_q   <= '0;
      counter_q  <= '0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      validity_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid_d) begin
            mcand_q    <= {{WIDTH{1'b0}}, a_mag_d};
            mplier_q   <= b_mag_d;
            neg_q      <= neg_d;
            acc_q      <= '0;
            counter_q  <= '0;
            busy_q     <= 1'b1;
            validity_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q     <= acc_d;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_d;
          counter_q <= counter_q + CW'(1);
          if (last_iter_d) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q   <= product_d;
          validity_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.validity = validity_q;
  assign bus.result   = result_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus pushes expected product and latency,
// a monitor pops on each rising validity and also watches that held results stay put.
module tb_seq_multiplier;
  localparam logic [3:0] OP_MULT  = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [31:0] last_exp = '0;

  seq_multiplier_if #(.WIDTH(16)) bus ();

  seq_multiplier #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    longint p;
    if (op == OP_MULTU) p = longint'(a) * longint'(b);
    else                p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [15:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [15:0] m;
    int hb;
    m  = (op == OP_MULT && b[15]) ? 16'(-b) : b;
    hb = 0;
    for (int i = 0; i < 16; i++) if (m[i]) hb = i + 1;
    return (hb == 0) ? 2 : hb + 1;
`else
    return 17;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Monitor: pops on each rising validity, then checks the result holds while validity stays high.
  initial begin
    logic        prev_v;
    logic        held;
    logic [31:0] held_val;
    exp_t        e;
    prev_v = 1'b0;
    held   = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (bus.validity === 1'b1 && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %h, want no completion", bus.result);
        end else begin
          e = exp_q.pop_front();
          check("result", bus.result, e.res);
          check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
          check("busy_at_done", {31'b0, bus.busy}, 32'd0);
          held = 1'b1;
          held_val = e.res;
        end
      end else if (bus.validity === 1'b1 && held) begin
        check("result_hold", bus.result, held_val);
      end
      if (bus.validity !== 1'b1) held = 1'b0;
      prev_v = (bus.validity === 1'b1);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit track, input logic [31:0] want);
    exp_t e;
    @(negedge clk);
    bus.control = op; bus.multiplicand = a; bus.multiplier = b;
    @(posedge clk); #1;
    bus.control = 4'h0;
    if (track) begin
      e.res = want; e.lat = model_lat(op, b); e.acc_cyc = cyc;
      exp_q.push_back(e);
      last_exp = want;
    end
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.validity === 1'b1) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout_%s: validity still low, want high within 40 cycles", name);
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [15:0] edge_vals [4];
    edge_vals[0] = 16'h0000; edge_vals[1] = 16'h8000;
    edge_vals[2] = 16'hFFFF; edge_vals[3] = 16'h7FFF;
    bus.control = 4'h0; bus.multiplicand = '0; bus.multiplier = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_valid", {31'b0, bus.validity}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;

    issue(OP_MULTU, 16'd51, 16'd5, 1'b1, 32'h000000FF);
    wait_done("multu_51_5");
    repeat (10) @(negedge clk);

    issue(OP_MULT, 16'hFFFD, 16'd7, 1'b1, 32'hFFFFFFEB);          wait_done("mult_neg3_7");
    issue(OP_MULT, 16'h8000, 16'h8000, 1'b1, 32'h40000000);       wait_done("mult_8000");
    issue(OP_MULTU, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001);      wait_done("multu_ffff");
    issue(OP_MULT, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);       wait_done("mult_ffff");
    issue(OP_MULTU, 16'd0, 16'd0, 1'b1, 32'h00000000);            wait_done("zero");

    // Mid-run opcodes must be dropped.
    issue(OP_MULTU, 16'd100, 16'd200, 1'b1, 32'h00004E20);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.control = OP_MULT; bus.multiplicand = 16'h1234; bus.multiplier = 16'h00FF;
    end
    @(negedge clk);
    bus.control = 4'h0;
    wait_done("midrun");
    repeat (3) begin
      @(negedge clk);
      check("no_second_op", {31'b0, bus.busy}, 32'd0);
    end

    // Invalid opcode in IDLE is ignored.
    @(negedge clk);
    bus.control = 4'b1001; bus.multiplicand = 16'd9; bus.multiplier = 16'd9;
    @(negedge clk);
    check("invalid_busy", {31'b0, bus.busy}, 32'd0);
    check("invalid_result", bus.result, last_exp);
    bus.control = 4'h0;

    // Reset mid-operation aborts and clears outputs.
    issue(OP_MULTU, 16'd300, 16'd400, 1'b0, 32'd0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_valid", {31'b0, bus.validity}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    issue(OP_MULTU, 16'd6, 16'd7, 1'b1, 32'h0000002A);            wait_done("after_abort");

    issue(OP_MULTU, 16'd1234, 16'd1, 1'b1, 32'h000004D2);         wait_done("b_one");

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
      a  = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 15));
      issue(op, a, b, 1'b1, model_res(op, a, b));
      wait_done("random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
